// File: rtl/prog_rom_sequencer.sv
// Writable program store plus a one-instruction-per-cycle INC/JNO/HLT/NOP sequencer.
// Optional run-cycle watchdog enabled by defining INSN_WDOG_EN.
module prog_rom_sequencer #(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W+1:0] wr_data,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              ovf,
  output logic              wr_reject,
  output logic              timeout
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IW    = ADDR_W + 2;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;

  if (ADDR_W < 1 || DATA_W < 2 || WDOG_CYCLES < 1) begin : g_bad_params
    $error("prog_rom_sequencer: illegal parameter values");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t state;

  logic [IW-1:0]     mem [DEPTH];
  logic [IW-1:0]     insn;
  logic [1:0]        op;
  logic [ADDR_W-1:0] target;

  assign insn   = mem[pc];
  assign op     = insn[IW-1:ADDR_W];
  assign target = insn[ADDR_W-1:0];

  // Power-on program: INC / JNO 0 / INC / HLT, every further word HLT.
  function automatic logic [IW-1:0] default_word(input int idx);
    logic [IW-1:0] w;
    w = {OP_HLT, {ADDR_W{1'b0}}};
    if (idx == 0 || idx == 2) w = {OP_INC, {ADDR_W{1'b0}}};
    if (idx == 1)             w = {OP_JNO, {ADDR_W{1'b0}}};
    return w;
  endfunction

  // Writes land only outside RUN so the running program is never modified.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= default_word(i);
    end else if (wr_en && state != ST_RUN) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef INSN_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;
  logic              timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      halted    <= 1'b0;
      pc        <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      wr_reject <= 1'b0;
`ifdef INSN_WDOG_EN
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      wr_reject <= wr_en && (state == ST_RUN);
      case (state)
        ST_RUN: begin
          case (op)
            OP_INC: begin
              acc <= acc + DATA_W'(1);
              if (&acc) ovf <= 1'b1;
              pc  <= pc + ADDR_W'(1);
            end
            OP_JNO: begin
              if (!ovf) begin
                pc <= target;
              end else begin
                pc  <= pc + ADDR_W'(1);
                ovf <= 1'b0;
              end
            end
            OP_HLT: begin
              state  <= ST_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
            default: pc <= pc + ADDR_W'(1);
          endcase
`ifdef INSN_WDOG_EN
          // The limiting instruction still executes; only the state changes.
          wdog_cnt <= wdog_cnt + WDOG_W'(1);
          if (op != OP_HLT && wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            state     <= ST_HALT;
            busy      <= 1'b0;
            halted    <= 1'b1;
            timeout_q <= 1'b1;
          end
`endif
        end
        default: begin
          if (start) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            halted <= 1'b0;
            pc     <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
`ifdef INSN_WDOG_EN
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_rom_sequencer.sv
// Directed bench for prog_rom_sequencer: expected halt states queued at start, checked at halt.
module tb_prog_rom_sequencer;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int SW     = ADDR_W + DATA_W + 4;

  localparam logic [ADDR_W+1:0] I_INC  = 4'b0000;
  localparam logic [ADDR_W+1:0] I_JNO0 = 4'b0100;
  localparam logic [ADDR_W+1:0] I_HLT  = 4'b1000;
  localparam logic [ADDR_W+1:0] I_NOP  = 4'b1100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W+1:0] wr_data;
  logic              busy, halted, ovf, wr_reject, timeout;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] exp_s;
  int checks = 0;
  int errors = 0;
  int n;

  prog_rom_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDOG_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .halted(halted), .pc(pc), .acc(acc),
    .ovf(ovf), .wr_reject(wr_reject), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] mk(input logic b, input logic h, input logic [ADDR_W-1:0] p,
                                       input logic [DATA_W-1:0] a, input logic o, input logic t);
    return {b, h, p, a, o, t};
  endfunction

  function automatic logic [SW-1:0] status();
    return {busy, halted, pc, acc, ovf, timeout};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [ADDR_W+1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int max, output int cnt);
    cnt = 0;
    while (!halted && cnt < max) begin
      step();
      cnt++;
    end
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp_s = exp_q.pop_front();
      check(tag, 32'(status()), 32'(exp_s));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    check("reset_status", 32'(status()), 32'(mk(0, 0, 0, 0, 0, 0)));
    check("reset_wr_reject", 32'(wr_reject), 32'd0);
    rst_n = 1'b1;

    // Default program: 16 INC/JNO pairs, fall-through, INC, HLT.
    do_start();
    check("s1_run_entry", 32'(status()), 32'(mk(1, 0, 0, 0, 0, 0)));
    exp_q.push_back(mk(0, 1, 3, 1, 0, 0));
    repeat (31) step();
    check("s1_overflow", 32'(status()), 32'(mk(1, 0, 1, 0, 1, 0)));
    wait_halt(20, n);
    check("s1_halt_edges", 32'(n), 32'd3);
    pop_check("s1_final");

    // Load from HALT: INC, INC, HLT.
    wr(0, I_INC); wr(1, I_INC); wr(2, I_HLT);
    do_start();
    exp_q.push_back(mk(0, 1, 2, 2, 0, 0));
    wait_halt(20, n);
    check("load_halt_edges", 32'(n), 32'd3);
    pop_check("load_final");

    // Mid-run reset restores the default program.
    wr(1, I_JNO0);
    do_start();
    repeat (10) step();
    check("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrun_reset", 32'(status()), 32'(mk(0, 0, 0, 0, 0, 0)));
    do_start();
    exp_q.push_back(mk(0, 1, 3, 1, 0, 0));
    wait_halt(50, n);
    check("restored_edges", 32'(n), 32'd34);
    pop_check("restored_final");

    // Write during RUN is dropped and flagged for one cycle.
    do_start();
    exp_q.push_back(mk(0, 1, 3, 1, 0, 0));
    repeat (5) step();
    wr_en = 1'b1; wr_addr = 0; wr_data = I_HLT;
    step();
    wr_en = 1'b0;
    check("wr_reject_pulse", 32'(wr_reject), 32'd1);
    step();
    check("wr_reject_clear", 32'(wr_reject), 32'd0);
    wait_halt(50, n);
    check("wr_run_edges", 32'(n), 32'd27);
    pop_check("wr_run_final");

    // pc wrap: NOP, NOP, NOP, INC then back to 0.
    do_reset();
    wr(0, I_NOP); wr(1, I_NOP); wr(2, I_NOP); wr(3, I_INC);
    do_start();
    repeat (3) step();
    check("wrap_pc3", 32'(status()), 32'(mk(1, 0, 3, 0, 0, 0)));
    step();
    check("wrap_pc0", 32'(status()), 32'(mk(1, 0, 0, 1, 0, 0)));
    repeat (4) step();
    check("wrap_second", 32'(status()), 32'(mk(1, 0, 0, 2, 0, 0)));
    do_reset();
    wr(1, I_NOP); wr(2, I_NOP); wr(3, I_INC); wr(0, I_HLT);
    do_start();
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    wait_halt(10, n);
    check("hlt0_edges", 32'(n), 32'd1);
    pop_check("hlt0_final");

    // Simultaneous write and start: new word0 is the first fetch.
    do_reset();
    wr_en = 1'b1; wr_addr = 0; wr_data = I_HLT; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    check("simul_entry", 32'(status()), 32'(mk(1, 0, 0, 0, 0, 0)));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
    wait_halt(10, n);
    check("simul_edges", 32'(n), 32'd1);
    pop_check("simul_final");

`ifdef INSN_WDOG_EN
    // Watchdog: tight JNO loop halts on the 64th executed instruction.
    do_reset();
    wr(0, I_JNO0);
    do_start();
    exp_q.push_back(mk(0, 1, 0, 0, 0, 1));
    wait_halt(100, n);
    check("wdog_edges", 32'(n), 32'd64);
    pop_check("wdog_final");
    do_start();
    check("wdog_restart", 32'(status()), 32'(mk(1, 0, 0, 0, 0, 0)));
    do_reset();
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
